mult_share_arbiter: RTL

- Round-robin arbiter/sequencer that shares one multi-cycle Vedic multiplier core among 4 requesters.
- Grants one requester at a time, captures its operands and drives the multiplier start/operand interface.
- Waits for the core's done strobe, then returns the product with a one-hot completion pulse to the granted requester.
- Sits between requester logic and the single multiplier instance in the top level.

---
 rtl/mult_share_arbiter_pkg.sv | 25 ++
 rtl/mult_share_arbiter_if.sv | 36 +++
 rtl/mult_share_arbiter_rr_pick_4.sv | 25 ++
 rtl/mult_share_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the mult_share_arbiter slice.
// Contents: requester count, id width, default WIDTH / TIMEOUT_CYC,
// FSM state encodings and an id-to-one-hot helper.
package mult_share_arbiter_pkg;

    localparam int unsigned NUM_REQ         = 4;
    localparam int unsigned ID_W            = 2;
    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    // FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Decode a requester index into a one-hot vector
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared multiplier core.
// Requester side : req, a_in, b_in (in) / gnt, gnt_id, done, p_out, busy, err (out)
// Core side      : mul_start, mul_a, mul_b (out) / mul_done, mul_p (in)
// Modports: slave = arbiter view, master = requesters + core view.
interface mult_share_arbiter_if
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       gnt;
    logic [ID_W-1:0]          gnt_id;
    logic [NUM_REQ-1:0]       done;
    logic [2*WIDTH-1:0]       p_out;
    logic                     busy;
    logic                     err;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_done;
    logic [2*WIDTH-1:0]       mul_p;

    modport slave (
        input  req, a_in, b_in, mul_done, mul_p,
        output gnt, gnt_id, done, p_out, busy, err, mul_start, mul_a, mul_b
    );

    modport master (
        output req, a_in, b_in, mul_done, mul_p,
        input  gnt, gnt_id, done, p_out, busy, err, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/mult_share_arbiter_rr_pick_4.sv
// Combinational round-robin picker for 4 requesters.
// Ports: req[3:0], last_id[1:0] in; pick_id[1:0], pick_valid out.
// Searches last_id+1, +2, +3, then last_id itself (mod 4).
module rr_pick_4
    import mult_share_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [ID_W-1:0]    pick_id,
    output logic               pick_valid
);

    // Walk farthest-first so the nearest asserted requester is written last
    always_comb begin
        pick_id    = '0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[ID_W'(last_id + ID_W'(k))]) begin
                pick_id    = ID_W'(last_id + ID_W'(k));
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle multiplier core
// among 4 requesters.
// Ports: clk, rst (async, active high), bus (mult_share_arbiter_if.slave).
// Optional macro MULT_SHARE_TIMEOUT_EN: abort WAIT after TIMEOUT_CYC cycles
// with p_out=0 and err pulsed alongside done; otherwise err is tied 0.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    mult_share_arbiter_if.slave     bus
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [2*WIDTH-1:0] p_out_q, p_out_d;
    logic               busy_q, busy_d;
    logic               mul_start_q, mul_start_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;

    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;

`ifdef MULT_SHARE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    rr_pick_4 u_pick (
        .req        (bus.req),
        .last_id    (last_id_q),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            done_q      <= '0;
            p_out_q     <= '0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
`ifdef MULT_SHARE_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            done_q      <= done_d;
            p_out_q     <= p_out_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
`ifdef MULT_SHARE_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        done_d      = '0;
        p_out_d     = p_out_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
`ifdef MULT_SHARE_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ISSUE;
                    gnt_id_d    = pick_id;
                    gnt_d       = id_to_onehot(pick_id);
                    mul_a_d     = bus.a_in[pick_id*WIDTH +: WIDTH];
                    mul_b_d     = bus.b_in[pick_id*WIDTH +: WIDTH];
                    mul_start_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MULT_SHARE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // A core answer on the limit cycle takes precedence over timeout
                if (bus.mul_done) begin
                    state_d = RESP;
                    p_out_d = bus.mul_p;
                    done_d  = id_to_onehot(gnt_id_q);
                end
`ifdef MULT_SHARE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = RESP;
                    p_out_d = '0;
                    done_d  = id_to_onehot(gnt_id_q);
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d   = IDLE;
                last_id_d = gnt_id_q;
                gnt_d     = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.done      = done_q;
    assign bus.p_out     = p_out_q;
    assign bus.busy      = busy_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
`ifdef MULT_SHARE_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
